// File: rtl/debug_slave_cmd_sync_pkg.sv
// Shared definitions for the debug-slave command synchroniser: parameter
// defaults, the queued command record and the occupancy-count width helper.
package debug_slave_cmd_sync_pkg;

    localparam int DR_W_DEF        = 38;
    localparam int IR_W_DEF        = 2;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int FIFO_DEPTH_DEF  = 4;
    localparam int ACT_BIT_DEF     = 35;

    // The count must reach FIFO_DEPTH itself, hence the +1.
    localparam int CNT_W_DEF = $clog2(FIFO_DEPTH_DEF + 1);

    typedef struct packed {
        logic [IR_W_DEF-1:0] ir;
        logic [DR_W_DEF-1:0] data;
    } cmd_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/debug_slave_cmd_sync_sync_bit.sv
// Multi-flop level synchroniser for one asynchronous strobe into clk.
module debug_slave_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/debug_slave_cmd_sync.sv
// Brings virtual-JTAG update strobes into clk and queues each captured
// {ir, dr} pair for a ready/valid consumer.
module debug_slave_cmd_sync
    import debug_slave_cmd_sync_pkg::*;
#(
    parameter int DR_W        = DR_W_DEF,
    parameter int IR_W        = IR_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int ACT_BIT     = ACT_BIT_DEF
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [DR_W-1:0]                     sr,
    input  logic [IR_W-1:0]                     ir_in,
    input  logic                                vs_udr,
    input  logic                                vs_uir,
    output logic                                cmd_valid,
    input  logic                                cmd_ready,
    output logic [DR_W-1:0]                     jdo,
    output logic [2**IR_W-1:0]                  cmd_ir_onehot,
    output logic                                take_action,
    output logic                                take_no_action,
    output logic                                ir_update,
    output logic [cnt_width(FIFO_DEPTH)-1:0]    cmd_count,
    output logic                                overflow,
    input  logic                                clr_overflow
);

    localparam int CNT_W = cnt_width(FIFO_DEPTH);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int REC_W = IR_W + DR_W;

    logic udr_sync, uir_sync;
    logic udr_prev_q, uir_prev_q;
    logic udr_pulse;

    debug_slave_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_udr (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (vs_udr),
        .q_o     (udr_sync)
    );

    debug_slave_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_uir (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (vs_uir),
        .q_o     (uir_sync)
    );

    assign udr_pulse = udr_sync & ~udr_prev_q;
    assign ir_update = uir_sync & ~uir_prev_q;

    logic [REC_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             full, pop, push_ok, drop;
    logic [REC_W-1:0] head;

    // A pop frees the slot the same edge, so a full queue still accepts a push.
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign cmd_valid = (count_q != '0);
    assign pop       = cmd_valid & cmd_ready;
    assign push_ok   = udr_pulse & (~full | pop);
    assign drop      = udr_pulse & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ovf_d = drop ? 1'b1 : (clr_overflow ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_prev_q <= 1'b0;
            uir_prev_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            udr_prev_q <= udr_sync;
            uir_prev_q <= uir_sync;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage needs no reset: every data output is gated by cmd_valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= {ir_in, sr};
    end

    assign head           = mem_q[rd_ptr_q];
    assign jdo            = cmd_valid ? head[DR_W-1:0] : '0;
    assign take_action    = cmd_valid &  head[ACT_BIT];
    assign take_no_action = cmd_valid & ~head[ACT_BIT];
    assign cmd_count      = count_q;
    assign overflow       = ovf_q;

    always_comb begin
        cmd_ir_onehot = '0;
        if (cmd_valid) cmd_ir_onehot[head[REC_W-1:DR_W]] = 1'b1;
    end

endmodule

// File: tb/tb_debug_slave_cmd_sync.sv
// Directed and randomised checks of debug_slave_cmd_sync against a queue-based
// reference model.
module tb_debug_slave_cmd_sync;
    import debug_slave_cmd_sync_pkg::*;

    localparam int DR_W  = 38;
    localparam int IR_W  = 2;
    localparam int SYNC  = 2;
    localparam int DEPTH = 4;
    localparam int ACT   = 35;
    localparam int CNT_W = 3;

    logic              clk;
    logic              reset_n;
    logic [DR_W-1:0]   sr;
    logic [IR_W-1:0]   ir_in;
    logic              vs_udr, vs_uir;
    logic              cmd_valid, cmd_ready;
    logic [DR_W-1:0]   jdo;
    logic [3:0]        cmd_ir_onehot;
    logic              take_action, take_no_action, ir_update;
    logic [CNT_W-1:0]  cmd_count;
    logic              overflow, clr_overflow;

    debug_slave_cmd_sync dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sr             (sr),
        .ir_in          (ir_in),
        .vs_udr         (vs_udr),
        .vs_uir         (vs_uir),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .jdo            (jdo),
        .cmd_ir_onehot  (cmd_ir_onehot),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .ir_update      (ir_update),
        .cmd_count      (cmd_count),
        .overflow       (overflow),
        .clr_overflow   (clr_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int ir_seen = 0;

    // Reference model: commands as a queue, strobes as sampled-level history.
    cmd_t       mq[$];
    logic       m_ovf = 1'b0;
    logic [7:0] udr_h = '0, uir_h = '0;
    logic       udr_pend = 1'b0, uir_pend = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_ovf    = 1'b0;
        udr_h    = '0;
        uir_h    = '0;
        udr_pend = 1'b0;
        uir_pend = 1'b0;
    endtask

    task automatic model_edge();
        logic pop, push, drop;
        cmd_t rec;
        if (!reset_n) begin
            model_clear();
            return;
        end
        pop  = (mq.size() > 0) && cmd_ready;
        push = udr_pend;
        rec  = '{ir: ir_in, data: sr};
        drop = push && (mq.size() == DEPTH) && !pop;
        if (drop) begin
            m_ovf = 1'b1;
        end else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(rec);
            if (clr_overflow) m_ovf = 1'b0;
        end
        // A strobe rise sampled at edge k becomes a pulse SYNC edges later.
        udr_h    = {udr_h[6:0], vs_udr};
        uir_h    = {uir_h[6:0], vs_uir};
        udr_pend = udr_h[SYNC-1] & ~udr_h[SYNC];
        uir_pend = uir_h[SYNC-1] & ~uir_h[SYNC];
    endtask

    task automatic check_outputs();
        cmd_t       h;
        logic       v;
        logic [3:0] oh;
        v  = (mq.size() > 0);
        h  = v ? mq[0] : '0;
        oh = v ? (4'b0001 << h.ir) : 4'b0000;
        chk("cmd_valid", 64'(cmd_valid), 64'(v));
        chk("cmd_count", 64'(cmd_count), 64'(mq.size()));
        chk("jdo", 64'(jdo), 64'(h.data));
        chk("cmd_ir_onehot", 64'(cmd_ir_onehot), 64'(oh));
        chk("take_action", 64'(take_action), 64'(v & h.data[ACT]));
        chk("take_no_action", 64'(take_no_action), 64'(v & ~h.data[ACT]));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("ir_update", 64'(ir_update), 64'(uir_pend));
        if (ir_update) ir_seen++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic strobe(input logic [DR_W-1:0] d, input logic [IR_W-1:0] ir,
                          input logic rdy_in_pulse, input logic clr_in_pulse,
                          input logic with_uir);
        sr     = d;
        ir_in  = ir;
        vs_udr = 1'b1;
        vs_uir = with_uir;
        tick();
        tick();
        cmd_ready    = rdy_in_pulse;
        clr_overflow = clr_in_pulse;
        tick();
        cmd_ready    = 1'b0;
        clr_overflow = 1'b0;
        tick();
        vs_udr = 1'b0;
        vs_uir = 1'b0;
        repeat (3) tick();
    endtask

    function automatic logic [DR_W-1:0] rand_dr();
        return {6'($urandom), $urandom};
    endfunction

    task automatic drain();
        cmd_ready = 1'b1;
        repeat (DEPTH + 1) tick();
        cmd_ready = 1'b0;
        tick();
    endtask

    logic [DR_W-1:0] saved [DEPTH];
    int              seen0;

    initial begin
        reset_n = 1'b0; sr = '0; ir_in = '0; vs_udr = 1'b0; vs_uir = 1'b0;
        cmd_ready = 1'b0; clr_overflow = 1'b0;
        #1;
        chk("reset_valid", 64'(cmd_valid), 64'(0));
        chk("reset_count", 64'(cmd_count), 64'(0));
        chk("reset_jdo", 64'(jdo), 64'(0));
        chk("reset_overflow", 64'(overflow), 64'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) tick();

        // Single command with the action bit (bit 35) set.
        sr = 38'h08_0000_0000; ir_in = 2'd2; vs_udr = 1'b1;
        tick();
        tick();
        chk("single_valid_edge2", 64'(cmd_valid), 64'(0));
        tick();
        chk("single_valid_edge3", 64'(cmd_valid), 64'(1));
        chk("single_jdo", 64'(jdo), 64'h08_0000_0000);
        chk("single_onehot", 64'(cmd_ir_onehot), 64'(4'b0100));
        chk("single_take_action", 64'(take_action), 64'(1));
        chk("single_count", 64'(cmd_count), 64'(1));
        tick();
        vs_udr = 1'b0;
        repeat (3) tick();
        drain();
        // Bit 37 only: the model decides take_action for this one.
        strobe(38'h20_0000_0000, 2'd2, 1'b0, 1'b0, 1'b0);
        drain();

        // Fill past depth, then drain in order.
        for (int i = 0; i < DEPTH + 1; i++) begin
            logic [DR_W-1:0] d;
            d = rand_dr();
            if (i < DEPTH) saved[i] = d;
            strobe(d, 2'($urandom), 1'b0, 1'b0, 1'b0);
        end
        chk("fill_count", 64'(cmd_count), 64'(4));
        chk("fill_overflow", 64'(overflow), 64'(1));
        cmd_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_order", 64'(jdo), 64'(saved[i]));
            tick();
        end
        cmd_ready = 1'b0;
        chk("drain_empty", 64'(cmd_valid), 64'(0));
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("overflow_cleared", 64'(overflow), 64'(0));

        // Full queue, pop in the push cycle.
        for (int i = 0; i < DEPTH; i++) strobe(rand_dr(), 2'($urandom), 1'b0, 1'b0, 1'b0);
        strobe(rand_dr(), 2'd3, 1'b1, 1'b0, 1'b0);
        chk("full_pushpop_count", 64'(cmd_count), 64'(4));
        chk("full_pushpop_overflow", 64'(overflow), 64'(0));
        drain();

        // Coincident update-DR and update-IR strobes.
        seen0 = ir_seen;
        strobe(rand_dr(), 2'd1, 1'b0, 1'b0, 1'b1);
        chk("coinc_ir_pulses", 64'(ir_seen - seen0), 64'(1));
        chk("coinc_count", 64'(cmd_count), 64'(1));
        chk("coinc_onehot", 64'(cmd_ir_onehot), 64'(4'b0010));
        drain();

        // Reset with entries queued, strobe held high across release.
        for (int i = 0; i < 3; i++) strobe(rand_dr(), 2'($urandom), 1'b0, 1'b0, 1'b0);
        chk("premid_count", 64'(cmd_count), 64'(3));
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(cmd_valid), 64'(0));
        chk("midrst_count", 64'(cmd_count), 64'(0));
        chk("midrst_jdo", 64'(jdo), 64'(0));
        chk("midrst_onehot", 64'(cmd_ir_onehot), 64'(0));
        chk("midrst_action", 64'(take_action | take_no_action), 64'(0));
        model_clear();
        sr = rand_dr(); ir_in = 2'd0; vs_udr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) tick();
        chk("held_udr_one_push", 64'(cmd_count), 64'(1));
        vs_udr = 1'b0;
        repeat (3) tick();

        // Dropped push colliding with a clear: set wins.
        for (int i = 0; i < DEPTH - 1; i++) strobe(rand_dr(), 2'($urandom), 1'b0, 1'b0, 1'b0);
        chk("collide_prefull", 64'(cmd_count), 64'(4));
        strobe(rand_dr(), 2'($urandom), 1'b0, 1'b1, 1'b0);
        chk("collide_overflow", 64'(overflow), 64'(1));
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("collide_cleared", 64'(overflow), 64'(0));
        drain();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) vs_udr = ~vs_udr;
            if ($urandom_range(0, 5) == 0) vs_uir = ~vs_uir;
            cmd_ready    = ($urandom_range(0, 2) == 0);
            clr_overflow = ($urandom_range(0, 15) == 0);
            sr    = rand_dr();
            ir_in = 2'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
